// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: multi-digit BCD up/down counter with a programmable
// inclusive BCD limit, wrap or saturate at the bounds, synchronous load with
// validity check, and registered active-low seven-segment outputs.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 is always shown).
module bcd_updown_counter #(
   parameter int unsigned DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  en,
   input  logic                  up_dn,
   input  logic                  sat,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic [4*DIGITS-1:0]   limit,
   output logic [4*DIGITS-1:0]   count_bcd,
   output logic [7*DIGITS-1:0]   seg,
   output logic                  tc,
   output logic                  load_err
);

   localparam int unsigned W  = 4 * DIGITS;
   localparam int unsigned SW = 7 * DIGITS;

   // Active-low pattern for one BCD digit (bit0 = a ... bit6 = g).
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'h40;
         4'd1:    p = 7'h79;
         4'd2:    p = 7'h24;
         4'd3:    p = 7'h30;
         4'd4:    p = 7'h19;
         4'd5:    p = 7'h12;
         4'd6:    p = 7'h02;
         4'd7:    p = 7'h78;
         4'd8:    p = 7'h00;
         4'd9:    p = 7'h10;
         default: p = 7'h7F;
      endcase
      return p;
   endfunction

   // Display pattern for a count of zero, used as the reset value of seg.
   function automatic logic [SW-1:0] seg_rst_val();
      logic [SW-1:0] v;
      v = '1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
         v[7*i +: 7] = (i == 0) ? 7'h40 : 7'h7F;
`else
         v[7*i +: 7] = 7'h40;
`endif
      end
      return v;
   endfunction

   localparam logic [SW-1:0] SEG_RST = seg_rst_val();

   logic [W-1:0]  count_q, count_d;
   logic [SW-1:0] seg_q, seg_d;
   logic          tc_q, tc_d;
   logic          load_err_q, load_err_d;

   logic          load_ok;
   logic          at_top;
   logic          at_zero;
   logic [W-1:0]  inc_val;
   logic [W-1:0]  dec_val;

   // Load is accepted only for valid BCD not above the limit.
   always_comb begin
      load_ok = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
      end
      // Once every digit is 0..9, an unsigned compare of the packed vector
      // is exactly an MSD-first digit-wise BCD compare.
      if (load_val > limit) load_ok = 1'b0;
   end

   // Bound detection for up and down steps.
   always_comb begin
      at_top  = (count_q >= limit);
      at_zero = (count_q == '0);
   end

   // Per-digit BCD increment (9->0 carry) and decrement (0->9 borrow) ripples.
   always_comb begin
      logic carry;
      logic borrow;
      carry   = 1'b1;
      borrow  = 1'b1;
      inc_val = count_q;
      dec_val = count_q;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (count_q[4*i +: 4] == 4'd9) begin
               inc_val[4*i +: 4] = 4'd0;
            end else begin
               inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
               carry             = 1'b0;
            end
         end
         if (borrow) begin
            if (count_q[4*i +: 4] == 4'd0) begin
               dec_val[4*i +: 4] = 4'd9;
            end else begin
               dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
               borrow            = 1'b0;
            end
         end
      end
   end

   // Next count and pulses: load beats step, step beats hold.
   always_comb begin
      count_d    = count_q;
      tc_d       = 1'b0;
      load_err_d = 1'b0;
      if (load) begin
         if (load_ok) count_d = load_val;
         else         load_err_d = 1'b1;
      end else if (tick && en) begin
         if (up_dn) begin
            if (at_top) begin
               tc_d = 1'b1;
               if (!sat) count_d = '0;
            end else begin
               count_d = inc_val;
            end
         end else begin
            if (at_zero) begin
               tc_d = 1'b1;
               if (!sat) count_d = limit;
            end else begin
               count_d = dec_val;
            end
         end
      end
   end

   // Segment decode of the current count, registered one cycle later.
   always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
      logic lead;
      lead = 1'b1;
`endif
      seg_d = '1;
      // Walk MSD first so leading zeros can be tracked across digits.
      for (int unsigned j = 0; j < DIGITS; j++) begin
`ifdef LEADING_ZERO_BLANK_EN
         if (lead && (DIGITS - 1 - j) != 0 && count_q[4*(DIGITS-1-j) +: 4] == 4'd0) begin
            seg_d[7*(DIGITS-1-j) +: 7] = 7'h7F;
         end else begin
            lead = 1'b0;
            seg_d[7*(DIGITS-1-j) +: 7] = seg_decode(count_q[4*(DIGITS-1-j) +: 4]);
         end
`else
         seg_d[7*(DIGITS-1-j) +: 7] = seg_decode(count_q[4*(DIGITS-1-j) +: 4]);
`endif
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q    <= '0;
         seg_q      <= SEG_RST;
         tc_q       <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         seg_q      <= seg_d;
         tc_q       <= tc_d;
         load_err_q <= load_err_d;
      end
   end

   assign count_bcd = count_q;
   assign seg       = seg_q;
   assign tc        = tc_q;
   assign load_err  = load_err_q;

endmodule
